// File: rtl/weight_loader.sv
// weight_loader: programs Ising core weights from a valid/ready command stream.
// Define WEIGHT_LOADER_VERIFY_EN to add readback verification with error reporting.
`timescale 1ns/1ps
module weight_loader #(
  parameter int unsigned N                = 8,
  parameter int unsigned RD_LATENCY       = 1,
  parameter logic [31:0] CMP_MASK         = 32'hFFFF_FFFF,
  parameter logic [7:0]  WEIGHT_ADDR_MASK = 8'hC0
) (
  input  logic        clk,
  input  logic        axi_rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] cmd_s,
  input  logic [10:0] cmd_d,
  input  logic [31:0] cmd_wdata,
  input  logic        err_clr,
  output logic        wready,
  output logic [31:0] wr_addr,
  output logic [31:0] wdata,
  output logic [31:0] rd_addr,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic [15:0] wr_count,
  output logic [15:0] rej_count,
  output logic        err_sticky,
  output logic [15:0] err_count,
  output logic [31:0] err_addr
);

  localparam logic [10:0] N_LIM     = 11'(N);
  localparam logic [3:0]  WAIT_LOAD = 4'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_CHECK
  } state_t;

  state_t      r_state;
  logic        r_cmd_ready;
  logic        r_wready;
  logic        r_busy;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wdata;
  logic [15:0] r_wr_count;
  logic [15:0] r_rej_count;

  logic [31:0] w_cmd_addr;
  logic        w_cmd_legal;
  logic        w_hs;

  assign w_cmd_addr  = {WEIGHT_ADDR_MASK, cmd_d, cmd_s, 2'b00};
  assign w_cmd_legal = (cmd_s < N_LIM) && (cmd_d < N_LIM);
  assign w_hs        = cmd_valid && r_cmd_ready;

`ifdef WEIGHT_LOADER_VERIFY_EN
  logic [31:0] r_rd_addr;
  logic [31:0] r_err_addr;
  logic [15:0] r_err_count;
  logic        r_err_sticky;
  logic [3:0]  r_wait;
  logic        w_mismatch;

  assign w_mismatch = ((rdata ^ r_wdata) & CMP_MASK) != '0;
`else
  logic w_unused;
  assign w_unused = ^{rdata, CMP_MASK, WAIT_LOAD, err_clr};
`endif

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_wready    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_addr   <= '0;
      r_wdata     <= '0;
      r_wr_count  <= '0;
      r_rej_count <= '0;
`ifdef WEIGHT_LOADER_VERIFY_EN
      r_rd_addr    <= '0;
      r_err_addr   <= '0;
      r_err_count  <= '0;
      r_err_sticky <= 1'b0;
      r_wait       <= '0;
`endif
    end else begin
`ifdef WEIGHT_LOADER_VERIFY_EN
      // Clear first; a mismatch in CHECK below overrides with its own value.
      if (err_clr) begin
        r_err_sticky <= 1'b0;
        r_err_count  <= '0;
      end
`endif
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_hs) begin
            if (w_cmd_legal) begin
              r_state     <= S_WRITE;
              r_cmd_ready <= 1'b0;
              r_busy      <= 1'b1;
              r_wready    <= 1'b1;
              r_wr_addr   <= w_cmd_addr;
              r_wdata     <= cmd_wdata;
              r_wr_count  <= r_wr_count + 16'd1;
            end else if (r_rej_count != '1) begin
              r_rej_count <= r_rej_count + 16'd1;
            end
          end
        end
        S_WRITE: begin
          r_wready <= 1'b0;
`ifdef WEIGHT_LOADER_VERIFY_EN
          r_rd_addr <= r_wr_addr;
          r_state   <= S_READ;
`else
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
`endif
        end
`ifdef WEIGHT_LOADER_VERIFY_EN
        S_READ: begin
          r_wait  <= WAIT_LOAD;
          r_state <= (RD_LATENCY <= 1) ? S_CHECK : S_WAIT;
        end
        S_WAIT: begin
          r_wait <= r_wait - 4'd1;
          if (r_wait <= 4'd1) r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          if (w_mismatch) begin
            r_err_sticky <= 1'b1;
            r_err_addr   <= r_rd_addr;
            if (err_clr)                r_err_count <= 16'd1;
            else if (r_err_count != '1) r_err_count <= r_err_count + 16'd1;
          end
        end
`endif
        default: begin
          r_state     <= S_IDLE;
          r_wready    <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign wready    = r_wready;
  assign wr_addr   = r_wr_addr;
  assign wdata     = r_wdata;
  assign busy      = r_busy;
  assign wr_count  = r_wr_count;
  assign rej_count = r_rej_count;

`ifdef WEIGHT_LOADER_VERIFY_EN
  assign rd_addr    = r_rd_addr;
  assign err_sticky = r_err_sticky;
  assign err_count  = r_err_count;
  assign err_addr   = r_err_addr;
`else
  assign rd_addr    = '0;
  assign err_sticky = 1'b0;
  assign err_count  = '0;
  assign err_addr   = '0;
`endif

endmodule
